// File: rtl/bqf_pkg.sv
// Shared encodings for the biquad filter sequencer: FSM states, frame phases
// and coefficient-bank addresses.
package bqf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_t;

    // A frame is four cycles; the sample enters at PH_XIN, the result is taken at PH_OUT.
    localparam logic [1:0] PH_XIN = 2'd3;
    localparam logic [1:0] PH_OUT = 2'd2;

    localparam logic [1:0] FLUSH_LAST = 2'd3;

    localparam logic [1:0] COEF_A = 2'd0;
    localparam logic [1:0] COEF_B = 2'd1;
    localparam logic [1:0] COEF_C = 2'd2;
    localparam logic [1:0] COEF_D = 2'd3;

endpackage

// File: rtl/bqf_coef_bank.sv
// Shadow/active coefficient register pair; the copy on apply sees a write made
// in the same cycle so a combined write+commit lands in the active set.
module bqf_coef_bank
    import bqf_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic        apply,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] c,
    output logic [31:0] d
);

    logic [31:0] shadow      [4];
    logic [31:0] shadow_next [4];
    logic [31:0] active      [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            shadow_next[i] = shadow[i];
            if (we && (addr == 2'(i))) begin
                shadow_next[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= shadow_next[i];
                if (apply) begin
                    active[i] <= shadow_next[i];
                end
            end
        end
    end

    assign a = active[COEF_A];
    assign b = active[COEF_B];
    assign c = active[COEF_C];
    assign d = active[COEF_D];

endmodule

// File: rtl/bqf_ctrl.sv
// Sequencer for a time-multiplexed biquad engine: frames the engine phases,
// injects samples, tracks result tokens and applies coefficient updates safely.
module bqf_ctrl
    import bqf_pkg::*;
#(
    parameter int LAT_FRAMES = 2,
    parameter int OVF_W      = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    input  logic             cfg_commit,
    output logic             eng_clr,
    output logic [1:0]       eng_phase,
    output logic [31:0]      eng_xin,
    output logic [31:0]      eng_a,
    output logic [31:0]      eng_b,
    output logic [31:0]      eng_c,
    output logic [31:0]      eng_d,
    input  logic [31:0]      eng_y,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic [OVF_W-1:0] ovf_cnt,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    state_t                state;
    logic [1:0]            phase;
    logic [1:0]            fcnt;
    logic [LAT_FRAMES-1:0] tok;
    logic [LAT_FRAMES-1:0] tok_shift;
    logic                  pending;
    logic                  in_run;
    logic                  at_xin;
    logic                  at_out;
    logic                  accept;
    logic                  capture;
    logic                  apply;

    assign in_run  = (state == RUN);
    assign at_xin  = in_run && (phase == PH_XIN);
    assign at_out  = in_run && (phase == PH_OUT);

    // Handshakes: a transfer happens on a cycle where valid and ready are both 1.
    // s_ready opens only at the injection phase; m_valid holds until m_ready.
    assign s_ready = at_xin && !pending && en && !clr;
    assign accept  = s_valid && s_ready;
    assign eng_xin = accept ? s_data : '0;

    assign eng_clr   = !in_run || clr;
    assign busy      = (state != IDLE) && !clr;
    assign eng_phase = phase;
    assign dbg_state = state;

    assign capture = at_out && tok[LAT_FRAMES-1];

    always_comb begin
        tok_shift[0] = accept;
        for (int i = 1; i < LAT_FRAMES; i++) begin
            tok_shift[i] = tok[i-1];
        end
    end

    // Coefficients only move outside RUN, or exactly at the frame edge into FLUSH.
    always_comb begin
        apply = 1'b0;
        case (state)
            IDLE:    apply = pending || cfg_commit;
            FLUSH:   apply = (fcnt == FLUSH_LAST) && en && (pending || cfg_commit);
            RUN:     apply = at_xin && en && pending;
            default: apply = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            phase   <= '0;
            fcnt    <= '0;
            tok     <= '0;
            pending <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            ovf_cnt <= '0;
        end else begin
            pending <= apply ? 1'b0 : (pending || cfg_commit);

            case (state)
                IDLE: begin
                    phase <= '0;
                    if (en) begin
                        state <= FLUSH;
                        fcnt  <= '0;
                        tok   <= '0;
                    end
                end
                FLUSH: begin
                    phase <= '0;
                    if (fcnt == FLUSH_LAST) begin
                        state <= en ? RUN : IDLE;
                        fcnt  <= '0;
                    end else begin
                        fcnt <= fcnt + 2'd1;
                    end
                end
                RUN: begin
                    phase <= phase + 2'd1;
                    if (at_xin) begin
                        tok <= tok_shift;
                        if (!en) begin
                            state <= IDLE;
                        end else if (pending) begin
                            state <= FLUSH;
                            fcnt  <= '0;
                            tok   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= '0;
                end
            endcase

            if (capture) begin
                m_data  <= eng_y;
                m_valid <= 1'b1;
                if (m_valid && !m_ready && (ovf_cnt != '1)) begin
                    ovf_cnt <= ovf_cnt + 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    bqf_coef_bank u_coef_bank (
        .clk   (clk),
        .clr   (clr),
        .we    (cfg_we),
        .addr  (cfg_addr),
        .wdata (cfg_wdata),
        .apply (apply),
        .a     (eng_a),
        .b     (eng_b),
        .c     (eng_c),
        .d     (eng_d)
    );

endmodule

// File: doc/bqf_ctrl.md
BQF_CTRL -- requirements
Module: bqf_ctrl

Interface
REQ-001 SHALL have parameter LAT_FRAMES, default 2, meaning frames from sample injection to the result appearing on eng_y.
REQ-002 SHALL have parameter OVF_W, default 16, meaning the width of the overflow counter.
REQ-003 SHALL run on one clock and use a synchronous, active-high reset: clk input 1, rising-edge clock; clr input 1, synchronous active-high reset.
REQ-004 SHALL have port en, input, 1 bit: run enable.
REQ-005 SHALL have port s_valid, input, 1 bit: input sample valid.
REQ-006 SHALL have port s_ready, output, 1 bit: input sample ready.
REQ-007 SHALL have port s_data, input, 32 bits: input sample.
REQ-008 SHALL have port cfg_we, input, 1 bit: shadow coefficient write strobe.
REQ-009 SHALL have port cfg_addr, input, 2 bits: coefficient select (0=A, 1=B, 2=C, 3=D).
REQ-010 SHALL have port cfg_wdata, input, 32 bits: coefficient write data.
REQ-011 SHALL have port cfg_commit, input, 1 bit: request to apply shadow coefficients.
REQ-012 SHALL have port eng_clr, output, 1 bit: engine delay-line clear.
REQ-013 SHALL have port eng_phase, output, 2 bits: engine mux select (phase).
REQ-014 SHALL have port eng_xin, output, 32 bits: engine input sample.
REQ-015 SHALL have ports eng_a, eng_b, eng_c and eng_d, outputs, 32 bits each: active coefficients.
REQ-016 SHALL have port eng_y, input, 32 bits: engine result.
REQ-017 SHALL have port m_valid, output, 1 bit: result valid.
REQ-018 SHALL have port m_ready, input, 1 bit: result ready.
REQ-019 SHALL have port m_data, output, 32 bits: result.
REQ-020 SHALL have port ovf_cnt, output, OVF_W bits: saturating count of dropped results.
REQ-021 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, FLUSH and RUN.
REQ-023 IDLE SHALL move to FLUSH when en=1; FLUSH SHALL move to RUN after exactly 4 cycles.
REQ-024 RUN SHALL move to IDLE after a phase-3 cycle with en=0, and to FLUSH after a phase-3 cycle with a commit pending.
REQ-025 eng_phase SHALL count 0,1,2,3 and wrap each cycle in RUN, and SHALL hold 0 in IDLE and FLUSH.
REQ-026 eng_clr SHALL be 1 whenever the state is not RUN.
REQ-027 s_ready SHALL equal 1 only in RUN with eng_phase=3 and no commit pending and en=1.
REQ-028 A sample SHALL be accepted on the cycle s_valid and s_ready are both 1; eng_xin SHALL be s_data on that cycle and 0 otherwise.
REQ-029 Phase 3 without an accepted sample SHALL inject a bubble (eng_xin=0) carrying no valid token.
REQ-030 A LAT_FRAMES-deep token shift register SHALL advance at each phase 3 and capture the accept bit.
REQ-031 When the token reaching the last stage is 1 at phase 2, eng_y SHALL be registered into m_data and m_valid SHALL be set the next cycle.
REQ-032 m_valid SHALL clear on the cycle after a cycle with m_valid=1 and m_ready=1.
REQ-033 A new result arriving while m_valid=1 and m_ready=0 SHALL overwrite m_data, keep m_valid=1, and increment ovf_cnt, saturating at all-ones.
REQ-034 A new result arriving on the same cycle that m_ready takes the old result SHALL load the new result with no overflow.
REQ-035 cfg_we SHALL write cfg_wdata into shadow[cfg_addr] at any time and in any state.
REQ-036 cfg_commit SHALL set a pending flag; a commit in IDLE SHALL copy shadow to active immediately.
REQ-037 A commit received in RUN SHALL copy shadow to active on the RUN to FLUSH transition; a commit in FLUSH SHALL be applied on entry to RUN.
REQ-038 When cfg_we and cfg_commit occur in the same cycle, the write SHALL be included in the committed set.
REQ-039 On every entry to FLUSH, all tokens SHALL clear (in-flight results discarded, not counted); m_valid/m_data SHALL be retained.
REQ-040 Active coefficients SHALL never change in RUN except at a phase-3 to FLUSH boundary.
REQ-041 Dropping en in FLUSH SHALL complete the 4-cycle flush and then go to IDLE.

Reset
REQ-042 When clr=1 at a clock edge, state SHALL become IDLE and phase 0.
REQ-043 Reset SHALL clear the token register, pending flag, shadow and active coefficients, m_data, m_valid and ovf_cnt to 0.
REQ-044 During reset, eng_clr=1, s_ready=0 and busy=0.
REQ-045 Reset asserted mid-frame SHALL abandon the frame without producing a result.

Structure
REQ-046 A shared package bqf_pkg SHALL hold the state encoding (IDLE=0, FLUSH=1, RUN=2), the phase constants (PH_XIN=3, PH_OUT=2) and the coefficient address constants.
REQ-047 A single sub-module bqf_coef_bank SHALL implement the shadow/active register pair and commit copy; all else SHALL be inline.

Verification
REQ-048 Bench SHALL cover: clr=1 then en=1 -> eng_clr=1 for 4 cycles, then eng_phase counts 0,1,2,3 repeating; s_ready pulses every 4th cycle at phase 3.
REQ-049 Bench SHALL cover: s_data=0x10 accepted, LAT_FRAMES=2 -> m_valid rises 8 cycles later (phase 2 capture +1), m_data=eng_y at capture.
REQ-050 Bench SHALL cover: m_ready=0 for 3 results -> ovf_cnt=2 and m_data equals the third result; then m_ready=1 -> m_valid clears next cycle.
REQ-051 Bench SHALL cover: cfg_we A=5 then cfg_commit at phase 1 -> eng_a unchanged until after phase 3, then 5; eng_clr high for 4 cycles; in-flight token gives no result.
REQ-052 Bench SHALL cover: cfg_we and cfg_commit in the same cycle in IDLE, cfg_addr=3, data 0x7 -> eng_d=0x7 on the next cycle.
REQ-053 Bench SHALL cover: clr asserted at phase 1 with a token in flight -> next cycle all outputs at reset values; no m_valid afterward.
